// File: rtl/control_word_sequencer.sv
// One-hot phase sequencer that drives a registered control word built from per-step masks.
// Optional feature: define CTRL_HOLD_EN to add an i_hold input that freezes a running sequence.
module control_word_sequencer #(
    parameter int NUM_STEPS  = 3,
    parameter int NUM_SIGS   = 5,
    parameter int CONTINUOUS = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_cfg_we,
    input  logic [$clog2(NUM_STEPS)-1:0] i_cfg_step,
    input  logic [NUM_SIGS-1:0]          i_cfg_mask,
`ifdef CTRL_HOLD_EN
    input  logic                         i_hold,
`endif
    output logic [NUM_STEPS-1:0]         o_step_onehot,
    output logic [NUM_SIGS-1:0]          o_ctrl,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_cfg_err,
    output logic [1:0]                   o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_STEPS-1:0]  r_step;
    logic [NUM_STEPS-1:0]  w_step_nxt;
    logic [NUM_STEPS-1:0]  w_adv_step;
    logic [NUM_SIGS-1:0]   r_ctrl;
    logic [NUM_SIGS-1:0]   w_ctrl_nxt;
    logic [NUM_SIGS-1:0]   w_adv_ctrl;
    logic [NUM_SIGS-1:0]   w_mask0;
    logic [NUM_SIGS-1:0]   r_mask [NUM_STEPS];
    logic                  r_cfg_err;
    logic                  w_cfg_ok;
    logic                  w_cfg_rej;
    logic                  w_hold;

`ifdef CTRL_HOLD_EN
    assign w_hold = i_hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_cfg_ok  = i_cfg_we && (r_state != S_RUN) && (int'(i_cfg_step) < NUM_STEPS);
    assign w_cfg_rej = i_cfg_we && !w_cfg_ok;

    // A step-0 write in the start cycle must reach the first ctrl load.
    assign w_mask0 = (w_cfg_ok && (i_cfg_step == '0)) ? i_cfg_mask : r_mask[0];

    assign w_adv_step = r_step[NUM_STEPS-1] ? NUM_STEPS'(1) : (r_step << 1);

    always_comb begin
        w_adv_ctrl = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (w_adv_step[i]) begin
                w_adv_ctrl = w_adv_ctrl | r_mask[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_ctrl_nxt  = r_ctrl;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_step_nxt  = NUM_STEPS'(1);
                    w_ctrl_nxt  = w_mask0;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state_nxt = S_DONE;
                    w_step_nxt  = '0;
                    w_ctrl_nxt  = '0;
                end else if (!w_hold) begin
                    if (r_step[NUM_STEPS-1] && (CONTINUOUS == 0)) begin
                        w_state_nxt = S_DONE;
                        w_step_nxt  = '0;
                        w_ctrl_nxt  = '0;
                    end else begin
                        w_step_nxt = w_adv_step;
                        w_ctrl_nxt = w_adv_ctrl;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = '0;
                w_ctrl_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = '0;
                w_ctrl_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_ctrl    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_cfg_err <= w_cfg_rej;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_mask[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_mask[i_cfg_step] <= i_cfg_mask;
        end
    end

    assign o_step_onehot = r_step;
    assign o_ctrl        = r_ctrl;
    assign o_busy        = (r_state == S_RUN);
    assign o_done        = (r_state == S_DONE);
    assign o_cfg_err     = r_cfg_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_control_word_sequencer.sv
// Bench for control_word_sequencer: one-pass and continuous instances share the same stimulus
// and are compared every cycle against a phase-index reference model.
module tb_control_word_sequencer;

  localparam int NS = 3;
  localparam int NG = 5;
  localparam int P_IDLE = -1;
  localparam int P_DONE = NS;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          in_rst   = 1'b1;
  logic          in_start = 1'b0;
  logic          in_stop  = 1'b0;
  logic          in_we    = 1'b0;
  logic [1:0]    in_step  = 2'd0;
  logic [NG-1:0] in_mask  = '0;
  logic          in_hold  = 1'b0;

  logic [NS-1:0] o_step  [2];
  logic [NG-1:0] o_ctrl  [2];
  logic          o_busy  [2];
  logic          o_done  [2];
  logic          o_err   [2];
  logic [1:0]    o_dbg   [2];

  control_word_sequencer #(.NUM_STEPS(NS), .NUM_SIGS(NG), .CONTINUOUS(0)) u_dut_once (
    .i_clk(clk), .i_rst(in_rst), .i_start(in_start), .i_stop(in_stop),
    .i_cfg_we(in_we), .i_cfg_step(in_step), .i_cfg_mask(in_mask),
`ifdef CTRL_HOLD_EN
    .i_hold(in_hold),
`endif
    .o_step_onehot(o_step[0]), .o_ctrl(o_ctrl[0]), .o_busy(o_busy[0]),
    .o_done(o_done[0]), .o_cfg_err(o_err[0]), .o_dbg_state(o_dbg[0])
  );

  control_word_sequencer #(.NUM_STEPS(NS), .NUM_SIGS(NG), .CONTINUOUS(1)) u_dut_wrap (
    .i_clk(clk), .i_rst(in_rst), .i_start(in_start), .i_stop(in_stop),
    .i_cfg_we(in_we), .i_cfg_step(in_step), .i_cfg_mask(in_mask),
`ifdef CTRL_HOLD_EN
    .i_hold(in_hold),
`endif
    .o_step_onehot(o_step[1]), .o_ctrl(o_ctrl[1]), .o_busy(o_busy[1]),
    .o_done(o_done[1]), .o_cfg_err(o_err[1]), .o_dbg_state(o_dbg[1])
  );

  // reference model: phase is -1 (idle), 0..NS-1 (running step k), NS (done)
  int            m_phase [2];
  logic [NG-1:0] m_mask  [2][NS];
  logic          m_err   [2];
  logic [NG-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input int d);
    logic running;
    logic hold_eff;
    running = (m_phase[d] >= 0) && (m_phase[d] < NS);
`ifdef CTRL_HOLD_EN
    hold_eff = in_hold;
`else
    hold_eff = 1'b0;
`endif
    if (in_rst) begin
      m_phase[d] = P_IDLE;
      m_err[d] = 1'b0;
      for (int i = 0; i < NS; i++) m_mask[d][i] = '0;
    end else begin
      m_err[d] = in_we && (running || int'(in_step) >= NS);
      if (in_we && !m_err[d]) m_mask[d][in_step] = in_mask;
      if (m_phase[d] == P_IDLE) begin
        if (in_start) m_phase[d] = 0;
      end else if (m_phase[d] == P_DONE) begin
        m_phase[d] = P_IDLE;
      end else if (in_stop) begin
        m_phase[d] = P_DONE;
      end else if (!hold_eff) begin
        if (m_phase[d] == NS - 1) m_phase[d] = (d == 1) ? 0 : P_DONE;
        else m_phase[d] = m_phase[d] + 1;
      end
    end
  endtask

  // scoreboard: expected ctrl per DUT is queued, then popped against the observed word
  task automatic tick();
    logic run;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      model_update(d);
      run = (m_phase[d] >= 0) && (m_phase[d] < NS);
      exp_q.push_back(run ? m_mask[d][m_phase[d]] : '0);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [NG-1:0] exp_ctrl;
      logic [NS-1:0] exp_step;
      logic run_d;
      run_d = (m_phase[d] >= 0) && (m_phase[d] < NS);
      exp_step = run_d ? NS'(1 << m_phase[d]) : '0;
      exp_ctrl = exp_q.pop_front();
      check($sformatf("dut%0d step_onehot", d), 32'(o_step[d]), 32'(exp_step));
      check($sformatf("dut%0d ctrl", d), 32'(o_ctrl[d]), 32'(exp_ctrl));
      check($sformatf("dut%0d busy", d), 32'(o_busy[d]), 32'(run_d));
      check($sformatf("dut%0d done", d), 32'(o_done[d]), 32'(m_phase[d] == P_DONE));
      check($sformatf("dut%0d cfg_err", d), 32'(o_err[d]), 32'(m_err[d]));
    end
  endtask

  // driver tasks
  task automatic idle_cycles(input int n);
    in_rst = 0; in_start = 0; in_stop = 0; in_we = 0; in_hold = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic rst, input logic start, input logic stop,
                       input logic we, input logic [1:0] step, input logic [NG-1:0] mask,
                       input logic hold);
    in_rst = rst; in_start = start; in_stop = stop; in_we = we;
    in_step = step; in_mask = mask; in_hold = hold;
    tick();
  endtask

  task automatic program_masks();
    drive(0, 0, 0, 1, 2'd0, 5'b10101, 0);
    drive(0, 0, 0, 1, 2'd1, 5'b01100, 0);
    drive(0, 0, 0, 1, 2'd2, 5'b00011, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = P_IDLE;
      m_err[d] = 1'b0;
      for (int i = 0; i < NS; i++) m_mask[d][i] = '0;
    end

    // reset state
    drive(1, 0, 0, 0, 2'd0, '0, 0);
    drive(1, 1, 1, 0, 2'd0, '0, 0);

    // single pass with programmed masks, then wrap on the continuous instance
    program_masks();
    drive(0, 1, 0, 0, 2'd0, '0, 0);
    idle_cycles(5);
    drive(0, 0, 1, 0, 2'd0, '0, 0);
    idle_cycles(2);

    // stop at step 1
    drive(0, 1, 0, 0, 2'd0, '0, 0);
    idle_cycles(1);
    drive(0, 0, 1, 0, 2'd0, '0, 0);
    idle_cycles(2);

    // rejected config writes: in RUN, and with an out-of-range step in IDLE
    drive(0, 1, 0, 0, 2'd0, '0, 0);
    drive(0, 0, 0, 1, 2'd1, 5'b11111, 0);
    drive(0, 0, 1, 0, 2'd0, '0, 0);
    idle_cycles(1);
    drive(0, 0, 0, 1, 2'd3, 5'b11111, 0);
    drive(0, 1, 0, 0, 2'd0, '0, 0);
    idle_cycles(2);
    drive(0, 0, 1, 0, 2'd0, '0, 0);
    idle_cycles(1);

    // step-0 write in the same cycle as start
    drive(0, 1, 0, 1, 2'd0, 5'b11000, 0);
    idle_cycles(1);
    drive(0, 0, 1, 0, 2'd0, '0, 0);
    idle_cycles(2);

    // reset mid-run clears masks; following run drives ctrl=0
    drive(0, 1, 0, 0, 2'd0, '0, 0);
    idle_cycles(1);
    drive(1, 0, 0, 0, 2'd0, '0, 0);
    drive(0, 1, 0, 0, 2'd0, '0, 0);
    idle_cycles(3);
    drive(0, 0, 1, 0, 2'd0, '0, 0);
    idle_cycles(1);

    // start held high through RUN and DONE
    program_masks();
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 2'd0, '0, 0);
    drive(0, 1, 1, 0, 2'd0, '0, 0);
    idle_cycles(3);

`ifdef CTRL_HOLD_EN
    drive(0, 1, 0, 0, 2'd0, '0, 0);
    drive(0, 0, 0, 0, 2'd0, '0, 1);
    drive(0, 0, 0, 0, 2'd0, '0, 1);
    drive(0, 0, 0, 0, 2'd0, '0, 0);
    drive(0, 0, 1, 0, 2'd0, '0, 1);
    idle_cycles(2);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 4) == 0),
            2'($urandom_range(0, 3)),
            NG'($urandom),
            ($urandom_range(0, 5) == 0));
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
